// File: rtl/obi_dmem_slave.sv
`default_nettype none
// ============================================================================
// Module   : obi_dmem_slave
// Brief    : Single-port OBI data memory with programmable grant delay and
//            response latency, byte-enabled writes and address error response.
// Revision : 1.0 - initial release
// ============================================================================
module obi_dmem_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int READY_DELAY = 0,
  parameter int VALID_LAT   = 1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        OBI_req,
  input  logic        OBI_we,
  input  logic [3:0]  OBI_be,
  input  logic [31:0] OBI_addr,
  input  logic [31:0] OBI_wdata,
  output logic        OBI_mem_rdy,
  output logic        OBI_valid,
  output logic [31:0] OBI_rdata,
  output logic        OBI_err
);

  localparam int c_AW   = $clog2(DEPTH_WORDS);
  localparam int c_MAXD = (READY_DELAY > VALID_LAT) ? READY_DELAY : VALID_LAT;
  localparam int c_CW   = (c_MAXD > 0) ? $clog2(c_MAXD + 1) : 1;
  localparam logic [32:0]     c_LIMIT    = 33'(DEPTH_WORDS) << 2;
  localparam logic [c_CW-1:0] c_GNT_LOAD = c_CW'((READY_DELAY > 0) ? READY_DELAY - 1 : 0);
  localparam logic [c_CW-1:0] c_LAT_LOAD = c_CW'(VALID_LAT - 1);

  typedef enum logic [1:0] {IDLE, GNT_WAIT, LAT, RESP} state_t;

  localparam state_t c_ACC_STATE = (VALID_LAT == 1) ? RESP : LAT;

  state_t          r_state, w_state_nxt;
  logic [c_CW-1:0] r_gnt_cnt, w_gnt_cnt_nxt;
  logic [c_CW-1:0] r_lat_cnt, w_lat_cnt_nxt;
  logic            r_err;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [DEPTH_WORDS];
  logic            w_rdy, w_accept, w_addr_err;
  logic [c_AW-1:0] w_idx;

  assign w_idx      = OBI_addr[c_AW+1:2];
  assign w_addr_err = (|OBI_addr[1:0]) || ({1'b0, OBI_addr} >= c_LIMIT);
  assign w_accept   = OBI_req && w_rdy;

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_cnt_nxt = r_gnt_cnt;
    w_lat_cnt_nxt = r_lat_cnt;
    w_rdy         = 1'b0;
    case (r_state)
      IDLE: begin
        if (READY_DELAY == 0) begin
          w_rdy = OBI_req;
          if (OBI_req) begin
            w_state_nxt   = c_ACC_STATE;
            w_lat_cnt_nxt = c_LAT_LOAD;
          end
        end else if (OBI_req) begin
          w_state_nxt   = GNT_WAIT;
          w_gnt_cnt_nxt = c_GNT_LOAD;
        end
      end
      GNT_WAIT: begin
        // A dropped request abandons the transaction without a response
        if (!OBI_req) begin
          w_state_nxt = IDLE;
        end else if (r_gnt_cnt == '0) begin
          w_rdy         = 1'b1;
          w_state_nxt   = c_ACC_STATE;
          w_lat_cnt_nxt = c_LAT_LOAD;
        end else begin
          w_gnt_cnt_nxt = r_gnt_cnt - 1'b1;
        end
      end
      LAT: begin
        w_lat_cnt_nxt = r_lat_cnt - 1'b1;
        if (r_lat_cnt <= c_CW'(1)) w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state   <= IDLE;
      r_gnt_cnt <= '0;
      r_lat_cnt <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt_cnt <= w_gnt_cnt_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
      if (w_accept) begin
        r_err   <= w_addr_err;
        r_rdata <= (w_addr_err || OBI_we) ? '0 : r_mem[w_idx];
      end
    end
  end

  // Array has no reset so it can map onto block RAM
  always_ff @(posedge CLK) begin
    if (RSTn && w_accept && OBI_we && !w_addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (OBI_be[i]) r_mem[w_idx][8*i +: 8] <= OBI_wdata[8*i +: 8];
      end
    end
  end

  assign OBI_mem_rdy = w_rdy;
  assign OBI_valid   = (r_state == RESP);
  assign OBI_err     = OBI_valid && r_err;
  assign OBI_rdata   = OBI_valid ? r_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_obi_dmem_slave.sv
`default_nettype none
// Bench for obi_dmem_slave: two instances (grant delay 0/latency 1 and
// grant delay 3/latency 2) checked against a word-array reference model.
module tb_obi_dmem_slave;

  localparam int RD0 = 0, VL0 = 1, RD1 = 3, VL1 = 2;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [1:0]       rstn, req, we, rdy, vld, err;
  logic [1:0][3:0]  be;
  logic [1:0][31:0] addr, wdata, rdata;

  obi_dmem_slave #(.DEPTH_WORDS(1024), .READY_DELAY(RD0), .VALID_LAT(VL0)) u_dut0 (
    .CLK(CLK), .RSTn(rstn[0]), .OBI_req(req[0]), .OBI_we(we[0]), .OBI_be(be[0]),
    .OBI_addr(addr[0]), .OBI_wdata(wdata[0]), .OBI_mem_rdy(rdy[0]),
    .OBI_valid(vld[0]), .OBI_rdata(rdata[0]), .OBI_err(err[0]));

  obi_dmem_slave #(.DEPTH_WORDS(1024), .READY_DELAY(RD1), .VALID_LAT(VL1)) u_dut1 (
    .CLK(CLK), .RSTn(rstn[1]), .OBI_req(req[1]), .OBI_we(we[1]), .OBI_be(be[1]),
    .OBI_addr(addr[1]), .OBI_wdata(wdata[1]), .OBI_mem_rdy(rdy[1]),
    .OBI_valid(vld[1]), .OBI_rdata(rdata[1]), .OBI_err(err[1]));

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] mdl [2][16];
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int rd_of(input int d);
    return (d == 0) ? RD0 : RD1;
  endfunction

  function automatic int vl_of(input int d);
    return (d == 0) ? VL0 : VL1;
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'd4096);
  endfunction

  // One complete transaction; checks grant/valid timing, pulse width and payload
  task automatic txn(input int d, input bit w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] wd);
    int          cyc, g, v, ng;
    bit          e;
    logic [31:0] exp_rd, obs_rd;
    logic        obs_err;
    cyc = 0; g = -1; v = -1; ng = 0;
    e = addr_bad(a);
    exp_rd = '0; obs_rd = '0; obs_err = 1'b0;
    if (!e && !w) exp_rd = mdl[d][a[5:2]];
    if (!e && w) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) mdl[d][a[5:2]][8*i +: 8] = wd[8*i +: 8];
    end
    @(posedge CLK); #1;
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    while (v < 0 && cyc < 30) begin
      @(negedge CLK);
      if (rdy[d]) begin ng++; g = cyc; end
      if (vld[d]) begin v = cyc; obs_rd = rdata[d]; obs_err = err[d]; end
      @(posedge CLK); #1;
      if (g >= 0) req[d] = 1'b0;
      cyc++;
    end
    req[d] = 1'b0;
    @(negedge CLK);
    check("one_pulse", 32'(vld[d]), 32'd0);
    check("gnt_cycle", 32'(g), 32'(rd_of(d)));
    check("gnt_count", 32'(ng), 32'd1);
    check("valid_cycle", 32'(v), 32'(rd_of(d) + vl_of(d)));
    check("err", 32'(obs_err), 32'(e));
    check("rdata", obs_rd, exp_rd);
    last_rdata = obs_rd;
  endtask

  // Request held across n reads of words 0..n-1; address advances after each grant
  task automatic held(input int d, input int n);
    int rd, vl, p, k, vi, cyc;
    bit gnow;
    rd = rd_of(d); vl = vl_of(d); p = rd + vl + 1;
    k = 0; vi = 0; cyc = 0;
    @(posedge CLK); #1;
    req[d] = 1'b1; we[d] = 1'b0; be[d] = 4'hF; addr[d] = 32'h0;
    while (vi < n && cyc < 60) begin
      @(negedge CLK);
      gnow = 1'b0;
      if (vld[d]) begin
        check("b2b_data", rdata[d], mdl[d][vi]);
        check("b2b_vcyc", 32'(cyc), 32'(rd + vi*p + vl));
        vi++;
      end
      if (rdy[d]) begin
        check("b2b_gcyc", 32'(cyc), 32'(rd + k*p));
        k++;
        gnow = 1'b1;
      end
      @(posedge CLK); #1;
      if (gnow) begin
        if (k < n) addr[d] = 32'(k*4);
        else req[d] = 1'b0;
      end
      cyc++;
    end
    req[d] = 1'b0;
    check("b2b_nvalid", 32'(vi), 32'(n));
    check("b2b_ngnt", 32'(k), 32'(n));
  endtask

  // Reset pulse during the latency cycle of the delayed instance
  task automatic abort_txn(input bit w, input logic [31:0] a, input logic [31:0] wd);
    int cyc, nv;
    bit g;
    cyc = 0; nv = 0; g = 1'b0;
    if (w) mdl[1][a[5:2]] = wd;
    @(posedge CLK); #1;
    req[1] = 1'b1; we[1] = w; be[1] = 4'hF; addr[1] = a; wdata[1] = wd;
    while (!g && cyc < 20) begin
      @(negedge CLK);
      if (rdy[1]) g = 1'b1;
      @(posedge CLK); #1;
      cyc++;
    end
    req[1] = 1'b0;
    check("abort_gnt", 32'(g), 32'd1);
    rstn[1] = 1'b0;
    @(posedge CLK); #1;
    rstn[1] = 1'b1;
    @(negedge CLK);
    check("abort_rst_vals", {rdy[1], vld[1], err[1]}, 32'd0);
    check("abort_rst_rdata", rdata[1], 32'd0);
    repeat (8) begin
      if (vld[1]) nv++;
      @(negedge CLK);
    end
    check("abort_no_valid", 32'(nv), 32'd0);
  endtask

  // Write request dropped while waiting for grant; must leave no trace
  task automatic drop_txn(input logic [31:0] a, input logic [31:0] wd);
    int ng, nv;
    ng = 0; nv = 0;
    @(posedge CLK); #1;
    req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = a; wdata[1] = wd;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (rdy[1]) ng++;
      if (vld[1]) nv++;
      @(posedge CLK); #1;
      if (c == 1) req[1] = 1'b0;
    end
    check("drop_no_gnt", 32'(ng), 32'd0);
    check("drop_no_valid", 32'(nv), 32'd0);
  endtask

  initial begin
    automatic int          d;
    automatic int          r;
    automatic logic [31:0] a;
    rstn = '0; req = '0; we = '0; be = '0; addr = '0; wdata = '0;
    last_rdata = '0;
    repeat (3) @(posedge CLK);
    #1 rstn = 2'b11;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      check("rst_vals", {rdy[i], vld[i], err[i]}, 32'd0);
      check("rst_rdata", rdata[i], 32'd0);
    end

    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 16; w++) txn(i, 1'b1, 4'hF, 32'(w*4), $urandom);

    txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    txn(0, 1'b0, 4'hF, 32'h10, 32'h0);
    check("rd_deadbeef", last_rdata, 32'hDEADBEEF);
    txn(0, 1'b1, 4'hF, 32'h20, 32'h11223344);
    txn(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
    txn(0, 1'b0, 4'h0, 32'h20, 32'h0);
    check("rd_be_merge", last_rdata, 32'h11BB33DD);

    for (int i = 0; i < 2; i++) begin
      txn(i, 1'b0, 4'hF, 32'h1002, 32'h0);
      txn(i, 1'b1, 4'hF, 32'h1000, 32'hCAFEF00D);
      txn(i, 1'b1, 4'h0, 32'h8, 32'h12345678);
      txn(i, 1'b0, 4'hF, 32'h0, 32'h0);
      txn(i, 1'b0, 4'hF, 32'h8, 32'h0);
    end

    held(0, 3);
    held(1, 3);

    for (int i = 0; i < 80; i++) begin
      d = i % 2;
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'(4096 + 4*$urandom_range(0, 2000));
      else if (r == 1) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else             a = 32'($urandom_range(0, 15)) << 2;
      txn(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
    end

    abort_txn(1'b0, 32'h14, 32'h0);
    txn(1, 1'b0, 4'hF, 32'h14, 32'h0);
    abort_txn(1'b1, 32'h18, 32'h5A5AA5A5);
    txn(1, 1'b0, 4'hF, 32'h18, 32'h0);
    check("abort_wr_kept", last_rdata, 32'h5A5AA5A5);
    drop_txn(32'h1C, 32'h0BADF00D);
    txn(1, 1'b0, 4'hF, 32'h1C, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
